regfile_z_param: RTL and testbench
==================================

REGFILE_Z_PARAM -- requirements
Module: regfile_z_param

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of registers; must be a power of 2 and at least 4.
REQ-002 SHALL have parameter WIDTH, default 32: register width in bits.
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1 to 4.
REQ-004 SHALL have parameter BYPASS, default 0: 1 enables write-to-read forwarding.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports wen0/wen1, input, 1 each: write enables for write ports 0 and 1.
REQ-008 SHALL have ports waddr0/waddr1, input, AW=$clog2(NREGS) each: write addresses.
REQ-009 SHALL have ports wdata0/wdata1, input, WIDTH each: write data.
REQ-010 SHALL have port raddr, input, NRD x AW: read addresses, packed with port 0 in the LSBs.
REQ-011 SHALL have port rdata, output, NRD x WIDTH: read data, packed with port 0 in the LSBs.
REQ-012 SHALL have port clr_req, input, 1: request a sequential clear of the whole register file.
REQ-013 SHALL have port clr_busy, output, 1: high while a clear is in progress.
REQ-014 SHALL have port clr_done, output, 1: one-cycle pulse when a clear completes.

Function
REQ-015 Register 0 SHALL always read zero; writes to address 0 SHALL be discarded.
REQ-016 Reads SHALL be combinational; rdata[i] = reg[raddr[i]].
REQ-017 A write SHALL become visible to reads on the cycle after the rising edge that performs it (BYPASS=0).
REQ-018 When wen0 and wen1 target the same nonzero address in the same cycle, port 1 SHALL win.
REQ-019 With BYPASS=1, a read whose address matches an enabled, nonzero, same-cycle write SHALL return that write's wdata; if both write ports match, it SHALL return port 1's data.
REQ-020 The clear FSM SHALL have three states: IDLE, CLEAR and DONE.
REQ-021 IDLE -> CLEAR SHALL occur when clr_req=1, loading idx=1.
REQ-022 In CLEAR the FSM SHALL write zero to reg[idx] once per cycle, incrementing idx.
REQ-023 The FSM SHALL move CLEAR -> DONE after idx=NREGS-1 is written; a clear therefore takes NREGS-1 cycles.
REQ-024 DONE SHALL assert clr_done for exactly one cycle, then return to IDLE.
REQ-025 clr_busy SHALL be 1 in the CLEAR and DONE states and 0 in IDLE.
REQ-026 While clr_busy=1, both write ports SHALL be ignored and clr_req SHALL be ignored.
REQ-027 While clr_busy=1, reads SHALL still return current array contents; BYPASS SHALL be suppressed.
REQ-028 If clr_req=1 in DONE, no new clear SHALL start; a new request is accepted only in IDLE.
REQ-029 idx SHALL be AW bits wide, and its increment after NREGS-1 SHALL not wrap into another write.

Reset
REQ-030 rst_n=0 SHALL asynchronously zero all registers, set the FSM to IDLE, set idx=0, and drive clr_busy=0 and clr_done=0.
REQ-031 Reset asserted mid-clear SHALL abort the clear; after release the FSM SHALL be in IDLE with all registers zero.
REQ-032 rdata SHALL read zero for every address after reset, in all parameterisations.

Structure
REQ-033 The clear FSM state enum and the AW derivation function SHALL reside in shared package regfile_pkg.
REQ-034 The clear sequencer (FSM plus idx counter) SHALL be sub-module regfile_clr_seq; the array, write arbitration and bypass logic SHALL stay in regfile_z_param.

Verification
REQ-035 Basic: write reg5=32'hDEAD_BEEF via port 0, then read it on the next cycle on all ports -> each port returns DEADBEEF; raddr=0 -> 0.
REQ-036 Dual-write conflict: wen0=wen1=1, both to address 7, wdata0=32'h1111, wdata1=32'h2222 -> reg7 reads 2222; the same conflict aimed at address 0 -> reg0 still reads 0.
REQ-037 Bypass: with BYPASS=1, write address 3 = 32'hA5A5 while reading address 3 in the same cycle -> rdata=A5A5 in that cycle; with BYPASS=0 -> old value that cycle, A5A5 the next.
REQ-038 Clear: fill registers 1..31 with nonzero data, pulse clr_req -> clr_busy high for 32 cycles, clr_done pulses on cycle 32 after acceptance, all reads 0; a write issued during busy is dropped.
REQ-039 Reset mid-clear: assert rst_n=0 at idx=10 -> FSM in IDLE, busy=0, all registers 0 immediately.
REQ-040 Random: 500 cycles of random writes, reads and occasional clears, checked against a reference model, with NREGS=16, WIDTH=8, NRD=3 and BYPASS in both settings.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register file: clear-sequencer state encoding and the
// address-width derivation used by every module in the slice.
`timescale 1ns/1ps
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks idx over registers 1..NREGS-1, one zero-write per
// cycle, then pulses clr_done for one cycle before returning to idle.
`timescale 1ns/1ps
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = addr_w(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          idx_d   = AW'(1);
        end
      end
      CLR_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Park idx at zero on exit so the wrap never looks like another write.
        if (idx_q == LAST) begin
          state_d = CLR_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      CLR_DONE: begin
        clr_busy = 1'b1;
        clr_done = 1'b1;
        state_d  = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_z_param.sv
// Parameterised register file with hardwired-zero r0, two write ports
// (port 1 wins on conflict), NRD combinational read ports and optional bypass.
`timescale 1ns/1ps
module regfile_z_param
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int WIDTH  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wen0,
  input  logic                              wen1,
  input  logic [addr_w(NREGS)-1:0]          waddr0,
  input  logic [addr_w(NREGS)-1:0]          waddr1,
  input  logic [WIDTH-1:0]                  wdata0,
  input  logic [WIDTH-1:0]                  wdata1,
  input  logic [NRD*addr_w(NREGS)-1:0]      raddr,
  output logic [NRD*WIDTH-1:0]              rdata,
  input  logic                              clr_req,
  output logic                              clr_busy,
  output logic                              clr_done
);

  localparam int AW = addr_w(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic                        clr_we;
  logic [AW-1:0]               clr_idx;
  logic                        we0, we1;

  regfile_clr_seq #(.NREGS(NREGS), .AW(AW)) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // Qualified enables: writes to r0 and writes during a clear never land.
  assign we0 = wen0 && !clr_busy && (waddr0 != '0);
  assign we1 = wen1 && !clr_busy && (waddr1 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q[0] <= '0;
      for (int r = 1; r < NREGS; r++) begin
        if (clr_we && clr_idx == AW'(r))
          regs_q[r] <= '0;
        else if (we1 && waddr1 == AW'(r))
          regs_q[r] <= wdata1;
        else if (we0 && waddr0 == AW'(r))
          regs_q[r] <= wdata0;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = raddr[p*AW +: AW];

    // we0/we1 already exclude r0 and busy, so forwarding inherits both rules.
    always_comb begin
      rv = regs_q[ra];
      if (BYPASS != 0) begin
        if (we0 && waddr0 == ra) rv = wdata0;
        if (we1 && waddr1 == ra) rv = wdata1;
      end
    end

    assign rdata[p*WIDTH +: WIDTH] = rv;
  end

endmodule

// File: tb/tb_regfile_z_param.sv
// Scoreboard bench: four register-file configurations share one stimulus
// stream; a behavioural model predicts outputs, a negedge monitor compares.
`timescale 1ns/1ps
module tb_regfile_z_param;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wen0 = 1'b0, wen1 = 1'b0, clr_req = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [4:0]  ra0 = '0, ra1 = '0, ra2 = '0;

  int cfg_n   [ND] = '{32, 32, 16, 16};
  int cfg_w   [ND] = '{32, 32, 8, 8};
  int cfg_nrd [ND] = '{2, 2, 3, 3};
  int cfg_byp [ND] = '{0, 1, 0, 1};

  logic [63:0]   rdA, rdB;
  logic [23:0]   rdC, rdD;
  logic [ND-1:0] busy, done;
  logic [9:0]    raddr32;
  logic [11:0]   raddr16;

  assign raddr32 = {ra1, ra0};
  assign raddr16 = {ra2[3:0], ra1[3:0], ra0[3:0]};

  regfile_z_param #(.NREGS(32), .WIDTH(32), .NRD(2), .BYPASS(0)) dA (
    .clk(clk), .rst_n(rst_n), .wen0(wen0), .wen1(wen1),
    .waddr0(wa0), .waddr1(wa1), .wdata0(wd0), .wdata1(wd1),
    .raddr(raddr32), .rdata(rdA), .clr_req(clr_req),
    .clr_busy(busy[0]), .clr_done(done[0]));

  regfile_z_param #(.NREGS(32), .WIDTH(32), .NRD(2), .BYPASS(1)) dB (
    .clk(clk), .rst_n(rst_n), .wen0(wen0), .wen1(wen1),
    .waddr0(wa0), .waddr1(wa1), .wdata0(wd0), .wdata1(wd1),
    .raddr(raddr32), .rdata(rdB), .clr_req(clr_req),
    .clr_busy(busy[1]), .clr_done(done[1]));

  regfile_z_param #(.NREGS(16), .WIDTH(8), .NRD(3), .BYPASS(0)) dC (
    .clk(clk), .rst_n(rst_n), .wen0(wen0), .wen1(wen1),
    .waddr0(wa0[3:0]), .waddr1(wa1[3:0]), .wdata0(wd0[7:0]), .wdata1(wd1[7:0]),
    .raddr(raddr16), .rdata(rdC), .clr_req(clr_req),
    .clr_busy(busy[2]), .clr_done(done[2]));

  regfile_z_param #(.NREGS(16), .WIDTH(8), .NRD(3), .BYPASS(1)) dD (
    .clk(clk), .rst_n(rst_n), .wen0(wen0), .wen1(wen1),
    .waddr0(wa0[3:0]), .waddr1(wa1[3:0]), .wdata0(wd0[7:0]), .wdata1(wd1[7:0]),
    .raddr(raddr16), .rdata(rdD), .clr_req(clr_req),
    .clr_busy(busy[3]), .clr_done(done[3]));

  // ---------------- reference model ----------------
  // mclr counts cycles since a clear was accepted: 0 idle, 1..N busy,
  // register k is zeroed at the end of cycle k, done shows during cycle N.
  logic [31:0] mreg [ND][32];
  int          mclr [ND];

  typedef struct packed {
    logic [ND-1:0][2:0][31:0] rd;
    logic [ND-1:0]            busy;
    logic [ND-1:0]            done;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] msk(input int d, input logic [31:0] v);
    if (cfg_w[d] >= 32) return v;
    return v & ((32'd1 << cfg_w[d]) - 32'd1);
  endfunction

  function automatic logic [31:0] mread(input int d, input logic [4:0] a);
    int am;
    logic [31:0] v;
    am = int'(a) % cfg_n[d];
    if (am == 0) return 32'd0;
    v = mreg[d][am];
    if (cfg_byp[d] != 0 && mclr[d] == 0) begin
      if (wen0 && (int'(wa0) % cfg_n[d]) == am) v = msk(d, wd0);
      if (wen1 && (int'(wa1) % cfg_n[d]) == am) v = msk(d, wd1);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mclr[d] = 0;
      for (int r = 0; r < 32; r++) mreg[d][r] = 32'd0;
    end
  endtask

  task automatic model_step();
    int a0, a1, n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      n  = cfg_n[d];
      a0 = int'(wa0) % n;
      a1 = int'(wa1) % n;
      if (mclr[d] == 0) begin
        if (wen0 && a0 != 0) mreg[d][a0] = msk(d, wd0);
        if (wen1 && a1 != 0) mreg[d][a1] = msk(d, wd1);
        if (clr_req) mclr[d] = 1;
      end else begin
        if (mclr[d] < n) mreg[d][mclr[d]] = 32'd0;
        mclr[d] = (mclr[d] == n) ? 0 : mclr[d] + 1;
      end
    end
  endtask

  task automatic predict();
    exp_t e;
    logic [4:0] ras [3];
    ras[0] = ra0; ras[1] = ra1; ras[2] = ra2;
    e = '0;
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < cfg_nrd[d]; p++) e.rd[d][p] = mread(d, ras[p]);
      e.busy[d] = (mclr[d] != 0);
      e.done[d] = (mclr[d] == cfg_n[d]);
    end
    q.push_back(e);
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_ra(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    ra0 = a; ra1 = b; ra2 = c;
  endtask

  // ---------------- monitor ----------------
  function automatic logic [31:0] act_rd(input int d, input int p);
    case (d)
      0:       return rdA[p*32 +: 32];
      1:       return rdB[p*32 +: 32];
      2:       return {24'd0, rdC[p*8 +: 8]};
      default: return {24'd0, rdD[p*8 +: 8]};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < cfg_nrd[d]; p++) begin
          got = act_rd(d, p);
          nvec++;
          if (got !== e.rd[d][p]) begin
            nerr++;
            $display("FAIL rdata dut%0d port%0d t=%0t: got %h want %h", d, p, $time, got, e.rd[d][p]);
          end
        end
        nvec++;
        if (busy[d] !== e.busy[d]) begin
          nerr++;
          $display("FAIL clr_busy dut%0d t=%0t: got %b want %b", d, $time, busy[d], e.busy[d]);
        end
        nvec++;
        if (done[d] !== e.done[d]) begin
          nerr++;
          $display("FAIL clr_done dut%0d t=%0t: got %b want %b", d, $time, done[d], e.done[d]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    model_reset();
    @(posedge clk); #1;
    set_ra(5'd5, 5'd7, 5'd3);
    repeat (2) cycle();
    rst_n = 1'b1;

    // every address reads zero out of reset
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a), 5'(a ^ 5));
      cycle();
    end

    // basic write then read on all ports, plus r0
    wen0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; set_ra(5'd5, 5'd5, 5'd5);
    cycle();
    idle(); cycle();
    set_ra(5'd0, 5'd5, 5'd0); cycle();

    // dual-write conflict, nonzero then zero address
    wen0 = 1'b1; wen1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
    wd0 = 32'h1111; wd1 = 32'h2222; set_ra(5'd7, 5'd7, 5'd7);
    cycle();
    idle(); cycle();
    wen0 = 1'b1; wen1 = 1'b1; wa0 = 5'd0; wa1 = 5'd0; set_ra(5'd0, 5'd0, 5'd0);
    cycle();
    idle(); cycle();

    // same-cycle read of the address being written
    wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5; set_ra(5'd3, 5'd3, 5'd3);
    cycle();
    idle(); cycle();

    // fill, clear, write during busy (dropped), clr_req held into DONE
    for (int a = 1; a < 32; a++) begin
      wen0 = 1'b1; wa0 = 5'(a); wd0 = $urandom() | 32'h0101_0101;
      set_ra(5'($urandom()), 5'($urandom()), 5'($urandom()));
      cycle();
    end
    idle(); clr_req = 1'b1; cycle();
    clr_req = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      idle();
      set_ra(5'(c), 5'(c - 1), 5'd9);
      if (c == 5) begin wen0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5A5A_5A5A; end
      if (c == 32) clr_req = 1'b1;
      cycle();
    end
    idle();
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a), 5'(a));
      cycle();
    end

    // reset in the middle of a clear
    for (int a = 1; a < 32; a++) begin
      wen1 = 1'b1; wa1 = 5'(a); wd1 = $urandom() | 32'h0101_0101;
      cycle();
    end
    idle(); clr_req = 1'b1; cycle();
    clr_req = 1'b0;
    guard = 0;
    while (mclr[0] != 10 && guard < 40) begin
      set_ra(5'(guard + 12), 5'(guard + 20), 5'(guard + 13));
      cycle();
      guard++;
    end
    if (mclr[0] != 10) begin
      nerr++;
      $display("FAIL clear_progress: got idx %0d want 10", mclr[0]);
    end
    rst_n = 1'b0;
    model_reset();
    set_ra(5'd20, 5'd30, 5'd14);
    cycle();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(31 - a), 5'(a ^ 9));
      cycle();
    end

    // random traffic
    for (int i = 0; i < 500; i++) begin
      wen0 = 1'($urandom_range(0, 1));
      wen1 = 1'($urandom_range(0, 1));
      wa0 = 5'($urandom()); wa1 = 5'($urandom());
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      wd0 = $urandom(); wd1 = $urandom();
      clr_req = ($urandom_range(0, 39) == 0);
      set_ra(5'($urandom()), 5'($urandom()), 5'($urandom()));
      if ($urandom_range(0, 2) == 0) ra0 = wa0;
      if ($urandom_range(0, 2) == 0) ra1 = wa1;
      cycle();
    end
    idle();

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
